// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared definitions between the 8-bit ALU and its result buffer:
//             widths, flag bit positions inside the packed flag vector, the
//             packed result record and the buffer FSM state type.
//  Ports    : (package, none)
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_W  = 8;
    localparam int OP_W   = 2;
    localparam int FLAG_W = 5;

    // Bit positions inside the packed {parity,overflow,greater,is_eq,less} vector
    localparam int FLG_PAR = 4;
    localparam int FLG_OVF = 3;
    localparam int FLG_GT  = 2;
    localparam int FLG_EQ  = 1;
    localparam int FLG_LT  = 0;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ALU_W-1:0]  y;
        logic [FLAG_W-1:0] flags;
    } alu_result_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock FIFO with a combinational (zero-latency) head read.
//             The caller is responsible for never pushing when full nor
//             popping when empty; level is the authoritative occupancy.
//  Ports    : clk        clock, all state on rising edge
//             rst_n      synchronous reset, active-low
//             push       write push_data at the tail this cycle
//             push_data  entry to write
//             pop        retire the head entry this cycle
//             head       head entry (all zeros while empty)
//             level      occupancy 0..DEPTH
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    // Storage needs no reset: nothing is read unless level says it was written.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap on plain overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Gate with occupancy so stale storage never shows after reset or drain.
    assign head  = (r_level != '0) ? r_mem[r_rd_ptr] : '0;
    assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/alu_result_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_result_buffer
//  Purpose  : Buffers ALU results (op, y, flags) in a FIFO towards a
//             valid/ready consumer, counts overflow and equality events with
//             saturating counters, and supports a drain request that stops
//             acceptance until the FIFO is empty.
//  Ports    : clk, rst_n          clock / synchronous active-low reset
//             in_valid, in_ready  producer handshake
//             op, y               op code and ALU result
//             parity, overflow, greater, is_eq, less   ALU flags
//             drain               pulse: stop accepting, empty the FIFO
//             out_valid,out_ready consumer handshake
//             out_op,out_y        head op / result
//             out_flags           {parity,overflow,greater,is_eq,less}
//             level               occupancy 0..DEPTH
//             ovf_cnt, eq_cnt     saturating event counters
//             draining            high while in the drain state
//  Revision : 1.0  initial release
// ============================================================================
module alu_result_buffer #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    parameter  int CNT_W  = 8,
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] y,
    input  logic              parity,
    input  logic              overflow,
    input  logic              greater,
    input  logic              is_eq,
    input  logic              less,
    input  logic              drain,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_op,
    output logic [DATA_W-1:0] out_y,
    output logic [4:0]        out_flags,
    output logic [LVL_W-1:0]  level,
    output logic [CNT_W-1:0]  ovf_cnt,
    output logic [CNT_W-1:0]  eq_cnt,
    output logic              draining
);

    import alu_pkg::*;

    localparam int               ENTRY_W = OP_W + DATA_W + FLAG_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t              r_state;
    logic [CNT_W-1:0]    r_ovf_cnt;
    logic [CNT_W-1:0]    r_eq_cnt;
    logic [FLAG_W-1:0]   w_flags;
    logic [ENTRY_W-1:0]  w_head;
    logic [LVL_W-1:0]    w_level;
    logic                w_push;
    logic                w_pop;
    logic                w_empty_next;

    always_comb begin
        w_flags          = '0;
        w_flags[FLG_PAR] = parity;
        w_flags[FLG_OVF] = overflow;
        w_flags[FLG_GT]  = greater;
        w_flags[FLG_EQ]  = is_eq;
        w_flags[FLG_LT]  = less;
    end

    // Acceptance depends only on state and occupancy, so a full FIFO refuses
    // a push even when the consumer pops in the same cycle.
    assign in_ready  = (r_state == RUN) && (w_level < LVL_W'(DEPTH));
    assign out_valid = (w_level != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data ({op, y, w_flags}),
        .pop       (w_pop),
        .head      (w_head),
        .level     (w_level)
    );

    assign {out_op, out_y, out_flags} = w_head;
    assign level = w_level;

    // No pushes happen while draining, so the FIFO is empty after this edge
    // when it is empty now or its last entry is popped now.
    assign w_empty_next = (w_level == '0) || ((w_level == LVL_W'(1)) && w_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            case (r_state)
                RUN:     if (drain)        r_state <= DRAIN;
                DRAIN:   if (w_empty_next) r_state <= RUN;
                default: r_state <= RUN;
            endcase
        end
    end

    assign draining = (r_state == DRAIN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf_cnt <= '0;
            r_eq_cnt  <= '0;
        end else if (w_push) begin
            if (overflow && (r_ovf_cnt != CNT_MAX)) begin
                r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
            end
            if (is_eq && (r_eq_cnt != CNT_MAX)) begin
                r_eq_cnt <= r_eq_cnt + CNT_W'(1);
            end
        end
    end

    assign ovf_cnt = r_ovf_cnt;
    assign eq_cnt  = r_eq_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_result_buffer
//  Purpose  : Self-checking bench for alu_result_buffer: directed scenarios
//             followed by a randomized run, all compared every cycle against
//             a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_result_buffer;

    import alu_pkg::*;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 8;
    localparam int LVL_W   = $clog2(DEPTH) + 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        op = '0;
    logic [DATA_W-1:0] y = '0;
    logic              parity = 1'b0;
    logic              overflow = 1'b0;
    logic              greater = 1'b0;
    logic              is_eq = 1'b0;
    logic              less = 1'b0;
    logic              drain = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [1:0]        out_op;
    logic [DATA_W-1:0] out_y;
    logic [4:0]        out_flags;
    logic [LVL_W-1:0]  level;
    logic [CNT_W-1:0]  ovf_cnt;
    logic [CNT_W-1:0]  eq_cnt;
    logic              draining;

    always #5 clk = ~clk;

    alu_result_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .y         (y),
        .parity    (parity),
        .overflow  (overflow),
        .greater   (greater),
        .is_eq     (is_eq),
        .less      (less),
        .drain     (drain),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op    (out_op),
        .out_y     (out_y),
        .out_flags (out_flags),
        .level     (level),
        .ovf_cnt   (ovf_cnt),
        .eq_cnt    (eq_cnt),
        .draining  (draining)
    );

    // Reference model
    alu_result_t q[$];
    int          m_ovf;
    int          m_eq;
    bit          m_drain;
    bit          m_known = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [7:0] yy, input bit ovf, input bit eq, input bit rdy);
        in_valid  = v;
        y         = yy;
        op        = 2'($urandom_range(0, 3));
        parity    = 1'($urandom_range(0, 1));
        greater   = 1'($urandom_range(0, 1));
        less      = 1'($urandom_range(0, 1));
        overflow  = ovf;
        is_eq     = eq;
        out_ready = rdy;
    endtask

    // One clock: compare outputs against the model, clock, then advance the model.
    task automatic cycle();
        alu_result_t h;
        alu_result_t e;
        bit exp_ir, do_push, do_pop, nd;
        #1;
        exp_ir = !m_drain && (q.size() < DEPTH);
        if (m_known) begin
            chk("in_ready", 32'(in_ready), 32'(exp_ir));
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("level", 32'(level), 32'(q.size()));
            chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
            chk("eq_cnt", 32'(eq_cnt), 32'(m_eq));
            chk("draining", 32'(draining), 32'(m_drain));
            if (q.size() != 0) begin
                h = q[0];
                chk("out_y", 32'(out_y), 32'(h.y));
                chk("out_op", 32'(out_op), 32'(h.op));
                chk("out_flags", 32'(out_flags), 32'(h.flags));
            end
        end
        do_push = in_valid && exp_ir;
        do_pop  = (q.size() != 0) && out_ready;
        e.op    = op;
        e.y     = y;
        e.flags = {parity, overflow, greater, is_eq, less};
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_ovf   = 0;
            m_eq    = 0;
            m_drain = 1'b0;
            m_known = 1'b1;
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back(e);
                if (overflow) m_ovf = (m_ovf + 1 > CNT_MAX) ? CNT_MAX : m_ovf + 1;
                if (is_eq)    m_eq  = (m_eq + 1 > CNT_MAX) ? CNT_MAX : m_eq + 1;
            end
            nd = m_drain;
            if (!m_drain)          nd = drain;
            else if (q.size() == 0) nd = 1'b0;
            m_drain = nd;
        end
        #1;
    endtask

    initial begin
        // 1. Reset then idle
        rst_n = 1'b0;
        drive(0, 8'h00, 0, 0, 0);
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_y", 32'(out_y), 32'd0);
        chk("reset_cnts", 32'({ovf_cnt, eq_cnt}), 32'd0);

        // 2. Fill with out_ready low, then pop in order
        foreach (q[i]) begin end
        drive(1, 8'h11, 0, 0, 0); cycle();
        drive(1, 8'h22, 0, 0, 0); cycle();
        drive(1, 8'h33, 0, 0, 0); cycle();
        drive(1, 8'h44, 0, 0, 0); cycle();
        drive(0, 8'h00, 0, 0, 0);
        chk("full_level", 32'(level), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("pop0_y", 32'(out_y), 32'h11);
        drive(0, 8'h00, 0, 0, 1); cycle();
        chk("pop1_y", 32'(out_y), 32'h22);
        cycle();
        chk("pop2_y", 32'(out_y), 32'h33);
        cycle();
        chk("pop3_y", 32'(out_y), 32'h44);
        cycle();
        chk("popped_empty", 32'(out_valid), 32'd0);

        // 3. Full FIFO with simultaneous push attempt and pop
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 8'(8'hA0 + i), 0, 0, 0);
            cycle();
        end
        drive(1, 8'h5A, 0, 0, 1); cycle();
        chk("full_pushpop_level", 32'(level), 32'd3);
        drive(1, 8'h5B, 0, 0, 0); cycle();
        chk("after_reject_level", 32'(level), 32'd4);
        drive(0, 8'h00, 0, 0, 1);
        repeat (DEPTH) cycle();

        // 4. Counter saturation
        for (int i = 0; i < 300; i++) begin
            drive(1, 8'($urandom), 1, 1, 1);
            cycle();
        end
        chk("ovf_sat", 32'(ovf_cnt), 32'd255);
        chk("eq_sat", 32'(eq_cnt), 32'd255);
        drive(0, 8'h00, 1, 1, 1); cycle();
        chk("ovf_hold", 32'(ovf_cnt), 32'd255);

        // 5. Drain with three entries, then drain while empty
        drive(1, 8'h01, 0, 0, 0); cycle();
        drive(1, 8'h02, 0, 0, 0); cycle();
        drive(1, 8'h03, 0, 0, 0); cycle();
        drive(0, 8'h00, 0, 0, 0);
        drain = 1'b1; cycle();
        drain = 1'b0;
        chk("drain_enter", 32'(draining), 32'd1);
        chk("drain_in_ready", 32'(in_ready), 32'd0);
        drive(1, 8'h77, 0, 0, 1);
        repeat (3) cycle();
        chk("drain_exit", 32'(draining), 32'd0);
        chk("drain_resume_ready", 32'(in_ready), 32'd1);
        drive(0, 8'h00, 0, 0, 1);
        cycle();
        drain = 1'b1; cycle();
        drain = 1'b0;
        chk("drain_empty_enter", 32'(draining), 32'd1);
        cycle();
        chk("drain_empty_exit", 32'(draining), 32'd0);

        // 6. Reset mid-operation
        drive(1, 8'hC1, 1, 1, 0); cycle();
        drive(1, 8'hC2, 1, 1, 0); cycle();
        drive(0, 8'h00, 0, 0, 0);
        rst_n = 1'b0; cycle();
        rst_n = 1'b1;
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_cnts", 32'({ovf_cnt, eq_cnt}), 32'd0);
        chk("midrst_draining", 32'(draining), 32'd0);
        cycle();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 7, 8'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 1) == 1);
            drain = ($urandom_range(0, 19) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
            cycle();
        end
        drain = 1'b0;
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
